// File: rtl/axi_sram_slave.sv
// AXI slave backed by a 32-bit-wide on-chip SRAM.
// Read and write channels are independent and each accepts one transaction
// at a time. Bursts of up to 16 beats are supported; FIXED keeps the address
// and INCR/WRAP step it by the beat size. Memory contents survive reset.
module axi_sram_slave #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  // Read address channel
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // Read data channel
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // Write address channel
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // Write data channel
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // Write response channel
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned Depth = 1 << ADDR_W;

  typedef enum logic [1:0] {RIdle, RRd, RData} r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

  // Sideband and upper-length bits carry no meaning for this memory.
  logic unused_inputs;
  assign unused_inputs = ^{wid, arlock, arcache, arprot, awlock, awcache, awprot,
                           arlen[7:4], awlen[7:4]};

  // Sizes beyond one word are clamped to a full word.
  function automatic logic [1:0] eff_size(input logic [2:0] size);
    return (size > 3'd2) ? 2'd2 : size[1:0];
  endfunction

  // FIXED holds the address; INCR and WRAP both step by the beat size.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [1:0]  size,
                                            input logic [1:0]  burst);
    if (burst == 2'b00) begin
      return addr;
    end
    return addr + (32'd1 << size);
  endfunction

  function automatic logic bad_req(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'd2) || burst[1];
  endfunction

  logic [31:0] mem [Depth];

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  r_state_e    r_state_q, r_state_d;
  logic [3:0]  rid_q;
  logic [31:0] raddr_q;
  logic [3:0]  rlen_q;
  logic [3:0]  rcnt_q;
  logic [1:0]  rsize_q;
  logic [1:0]  rburst_q;
  logic        rerr_q;
  logic [31:0] rdata_q;
  logic        ar_fire;
  logic        r_fire;
  logic        r_last_beat;

  assign arready     = (r_state_q == RIdle) && !reset;
  assign rvalid      = (r_state_q == RData) && !reset;
  assign ar_fire     = arvalid && arready;
  assign r_fire      = rvalid && rready;
  assign r_last_beat = (rcnt_q == rlen_q);
  assign rlast       = rvalid && r_last_beat;
  assign rid         = reset ? 4'd0 : rid_q;
  assign rresp       = (!reset && rerr_q) ? 2'b10 : 2'b00;
  assign rdata       = rdata_q;

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= RIdle;
    end else begin
      r_state_q <= r_state_d;
    end
  end

  // Read FSM next state: one RRd bubble precedes every data beat.
  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (ar_fire) r_state_d = RRd;
      RRd:     r_state_d = RData;
      RData:   if (r_fire) r_state_d = r_last_beat ? RIdle : RRd;
      default: r_state_d = RIdle;
    endcase
  end

  // Read request latch and per-beat address/counter advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      rid_q    <= 4'd0;
      raddr_q  <= 32'd0;
      rlen_q   <= 4'd0;
      rcnt_q   <= 4'd0;
      rsize_q  <= 2'd0;
      rburst_q <= 2'b00;
      rerr_q   <= 1'b0;
    end else if (ar_fire) begin
      rid_q    <= arid;
      raddr_q  <= araddr;
      rlen_q   <= arlen[3:0];
      rcnt_q   <= 4'd0;
      rsize_q  <= eff_size(arsize);
      rburst_q <= arburst;
      rerr_q   <= bad_req(arsize, arburst);
    end else if (r_fire && !r_last_beat) begin
      raddr_q <= next_addr(raddr_q, rsize_q, rburst_q);
      rcnt_q  <= rcnt_q + 4'd1;
    end
  end

  // Synchronous memory read; the non-blocking read sees pre-write data on a collision.
  always_ff @(posedge clk) begin
    if (r_state_q == RRd) begin
      rdata_q <= mem[raddr_q[ADDR_W+1:2]];
    end
  end

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  w_state_e    w_state_q, w_state_d;
  logic [3:0]  bid_q;
  logic [31:0] waddr_q;
  logic [3:0]  wlen_q;
  logic [3:0]  wcnt_q;
  logic [1:0]  wsize_q;
  logic [1:0]  wburst_q;
  logic        werr_q;
  logic        aw_fire;
  logic        w_fire;
  logic        b_fire;
  logic        w_last_beat;

  assign awready     = (w_state_q == WIdle) && !reset;
  assign wready      = (w_state_q == WData) && !reset;
  assign bvalid      = (w_state_q == WResp) && !reset;
  assign aw_fire     = awvalid && awready;
  assign w_fire      = wvalid && wready;
  assign b_fire      = bvalid && bready;
  assign w_last_beat = (wcnt_q == wlen_q);
  assign bid         = reset ? 4'd0 : bid_q;
  assign bresp       = (bvalid && werr_q) ? 2'b10 : 2'b00;

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= WIdle;
    end else begin
      w_state_q <= w_state_d;
    end
  end

  // Write FSM next state: the burst ends on the counted length, never on wlast.
  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (aw_fire) w_state_d = WData;
      WData:   if (w_fire && w_last_beat) w_state_d = WResp;
      WResp:   if (b_fire) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  // Write request latch, beat advance and sticky error accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      bid_q    <= 4'd0;
      waddr_q  <= 32'd0;
      wlen_q   <= 4'd0;
      wcnt_q   <= 4'd0;
      wsize_q  <= 2'd0;
      wburst_q <= 2'b00;
      werr_q   <= 1'b0;
    end else if (aw_fire) begin
      bid_q    <= awid;
      waddr_q  <= awaddr;
      wlen_q   <= awlen[3:0];
      wcnt_q   <= 4'd0;
      wsize_q  <= eff_size(awsize);
      wburst_q <= awburst;
      werr_q   <= bad_req(awsize, awburst);
    end else if (w_fire) begin
      waddr_q <= next_addr(waddr_q, wsize_q, wburst_q);
      wcnt_q  <= wcnt_q + 4'd1;
      werr_q  <= werr_q || (wlast != w_last_beat);
    end
  end

  // Byte-lane memory write in the W handshake cycle.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[waddr_q[ADDR_W+1:2]][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
